shared_mem_responder: RTL and testbench
=======================================

SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, word width in bits.
REQ-003 SHALL have parameter PROT_BASE, default 12'hF00, lowest write-protected address.
REQ-004 SHALL have port clkx  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port addr_  input  ADDR_W  access address from the arbiter.
REQ-007 SHALL have port we_  input  1  write enable; 1 = write, 0 = read.
REQ-008 SHALL have port dataIN_  input  DATA_W  write data.
REQ-009 SHALL have port dataOUT_  output  DATA_W  registered read data.
REQ-010 SHALL have port rd_slot  output  1  arbiter slot (0/1) that owns the current dataOUT_.
REQ-011 SHALL have port ready  output  1  high when accesses are serviced.
REQ-012 SHALL have port prot_err  output  1  one-cycle pulse on a rejected protected write.
REQ-013 SHALL have ports rd_count and wr_count  output  16 each  serviced read and write counters.

Function
REQ-014 SHALL hold storage of 2^ADDR_W words of DATA_W bits.
REQ-015 SHALL service one access per clkx cycle while ready=1; inputs are sampled at the rising edge.
REQ-016 SHALL register a read (we_=0) so that dataOUT_ = mem[addr_] one cycle after sampling.
REQ-017 SHALL write dataIN_ to mem[addr_] on a write with addr_ < PROT_BASE; write-first: dataOUT_ shows dataIN_ the next cycle.
REQ-018 SHALL NOT modify memory on a write with addr_ >= PROT_BASE; SHALL pulse prot_err for one cycle; dataOUT_ shows the unchanged stored word.
REQ-019 SHALL toggle an internal slot bit every cycle while ready=1, starting at 0 on the first ready cycle; rd_slot = slot bit of the access whose result is on dataOUT_.
REQ-020 SHALL increment rd_count per serviced read and wr_count per accepted (unprotected) write; both saturate at 16'hFFFF.
REQ-021 SHALL, while ready=0, ignore all accesses: no writes, no counter change, prot_err=0, dataOUT_ held.
REQ-022 SHALL make write-then-read to the same address in consecutive cycles return the newly written data.

Reset
REQ-023 SHALL on rst=1 set dataOUT_=0, rd_slot=0, prot_err=0, rd_count=0, wr_count=0 and the slot bit to 0.
REQ-024 SHALL NOT clear memory contents on reset except via the REQ-026 feature.
REQ-025 SHALL restart from the REQ-023 state when rst is asserted mid-operation, including mid-clear; a clear in progress restarts at address 0.

Configuration
REQ-026 SHALL, with macro SHARED_MEM_CLEAR_EN defined, run a state machine CLEAR -> READY: reset enters CLEAR with ready=0; CLEAR writes 0 to one address per cycle, 0 to 2^ADDR_W-1, ignoring PROT_BASE; after the last address it moves to READY and asserts ready. Total: 2^ADDR_W cycles.
REQ-027 SHALL, without SHARED_MEM_CLEAR_EN, omit the clear FSM: ready=1 from the first cycle after reset deasserts, and memory is not initialised.

Verification
REQ-028 Write 0x1234 to 0x010, read 0x010 next cycle -> dataOUT_=0x1234 one cycle after the read, wr_count=1, rd_count=1.
REQ-029 Write 0xBEEF to 0xF00 -> prot_err=1 for one cycle; read 0xF00 returns its prior value; wr_count unchanged.
REQ-030 Alternate reads to 0x001 and 0x002 holding 0xAAAA and 0x5555 -> dataOUT_ alternates 0xAAAA/0x5555 with rd_slot 0/1.
REQ-031 Force rd_count to 0xFFFE, issue 3 reads -> rd_count ends at 0xFFFF.
REQ-032 SHARED_MEM_CLEAR_EN: assert rst, then after 2000 cycles assert rst again -> ready=0 for 4096 cycles after the second reset; all addresses read 0 afterwards.
REQ-033 During CLEAR, write 0x7777 to 0x005 -> ignored; after ready, 0x005 reads 0.

Source files
------------

// File: rtl/shared_mem_responder.sv
// Single-port shared memory with write protection above PROT_BASE, slot tagging and access counters.
// Optional power-up clear state machine enabled by defining SHARED_MEM_CLEAR_EN.
module shared_mem_responder #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] PROT_BASE = 12'hF00
) (
  input  logic              clkx,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_,
  input  logic              we_,
  input  logic [DATA_W-1:0] dataIN_,
  output logic [DATA_W-1:0] dataOUT_,
  output logic              rd_slot,
  output logic              ready,
  output logic              prot_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              slot_q;
  logic              prot_hit_c;
  logic              wr_ok_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_wa_c;
  logic [DATA_W-1:0] mem_wd_c;

  assign prot_hit_c = (addr_ >= PROT_BASE);
  assign wr_ok_c    = ready & we_ & ~prot_hit_c;

`ifdef SHARED_MEM_CLEAR_EN
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              ready_d;
  logic              clr_we_c;

  always_ff @(posedge clkx) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready      <= ready_d;
    end
  end

  // Sweep every address with zero, then hand over to normal service
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = 1'b0;
    clr_we_c   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we_c   = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: ready_d = 1'b1;
      default: state_d = S_CLEAR;
    endcase
  end

  assign mem_we_c = ~rst & (clr_we_c | wr_ok_c);
  assign mem_wa_c = clr_we_c ? clr_addr_q : addr_;
  assign mem_wd_c = clr_we_c ? '0 : dataIN_;
`else
  always_ff @(posedge clkx) begin
    if (rst) ready <= 1'b0;
    else     ready <= 1'b1;
  end

  assign mem_we_c = ~rst & wr_ok_c;
  assign mem_wa_c = addr_;
  assign mem_wd_c = dataIN_;
`endif

  // Storage is deliberately not reset
  always_ff @(posedge clkx) begin
    if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

  // Read/write-first data path, slot tagging and saturating counters
  always_ff @(posedge clkx) begin
    if (rst) begin
      dataOUT_ <= '0;
      rd_slot  <= 1'b0;
      prot_err <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
      slot_q   <= 1'b0;
    end else begin
      prot_err <= 1'b0;
      if (ready) begin
        slot_q  <= ~slot_q;
        rd_slot <= slot_q;
        if (wr_ok_c) begin
          dataOUT_ <= dataIN_;
          if (wr_count != CNT_MAX) wr_count <= wr_count + 16'd1;
        end else begin
          dataOUT_ <= mem[addr_];
          if (we_) prot_err <= 1'b1;
          else if (rd_count != CNT_MAX) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomised bench for shared_mem_responder against an array-based reference model.
// Covers the clear sequence too when SHARED_MEM_CLEAR_EN is defined.
module tb_shared_mem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam logic [11:0] PROT  = 12'hF00;

  logic        clkx = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr_ = '0;
  logic        we_ = 1'b0;
  logic [15:0] dataIN_ = '0;
  logic [15:0] dataOUT_;
  logic        rd_slot, ready, prot_err;
  logic [15:0] rd_count, wr_count;

  shared_mem_responder dut (
    .clkx(clkx), .rst(rst), .addr_(addr_), .we_(we_), .dataIN_(dataIN_),
    .dataOUT_(dataOUT_), .rd_slot(rd_slot), .ready(ready), .prot_err(prot_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clkx = ~clkx;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  logic [15:0] m_dout = '0;
  bit          m_dval = 1'b0;
  bit          m_slot = 1'b0, m_slot_out = 1'b0, m_prot = 1'b0, m_ready = 1'b0;
  int          m_rd = 0, m_wr = 0, m_clr_left = 0;

  // One clock: drive at negedge, advance the model at posedge, settle 1 time unit
  task automatic tick(input bit r, input bit w, input logic [11:0] a, input logic [15:0] d);
    @(negedge clkx);
    rst = r; we_ = w; addr_ = a; dataIN_ = d;
    @(posedge clkx);
    if (r) begin
      m_dout = '0; m_dval = 1'b1; m_slot_out = 1'b0; m_prot = 1'b0;
      m_rd = 0; m_wr = 0; m_slot = 1'b0; m_ready = 1'b0; m_clr_left = DEPTH;
    end else begin
      m_prot = 1'b0;
      if (m_ready) begin
        m_slot_out = m_slot;
        m_slot = ~m_slot;
        if (w && a < PROT) begin
          m_mem[a] = d; m_val[a] = 1'b1; m_dout = d; m_dval = 1'b1;
          if (m_wr < 65535) m_wr++;
        end else begin
          m_dout = m_mem[a]; m_dval = m_val[a];
          if (w) m_prot = 1'b1;
          else if (m_rd < 65535) m_rd++;
        end
      end else begin
`ifdef SHARED_MEM_CLEAR_EN
        if (m_clr_left > 0) begin
          m_mem[DEPTH - m_clr_left] = '0;
          m_val[DEPTH - m_clr_left] = 1'b1;
          m_clr_left--;
          if (m_clr_left == 0) m_ready = 1'b1;
        end
`else
        m_ready = 1'b1;
`endif
      end
    end
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 5000; i++) begin
      tick(1'b0, 1'b0, 12'h000, 16'h0);
      n_checks++;
      if (ready !== m_ready) begin
        n_fail++;
        $display("FAIL ready_rise got=%b exp=%b cycle=%0d", ready, m_ready, i);
      end
      if (m_ready) break;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 12'h010, 16'hFFFF);
    tick(1'b1, 1'b0, 12'h000, 16'h0);
    n_checks++;
    if ({dataOUT_, rd_slot, prot_err, rd_count, wr_count} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got dout=%h slot=%b perr=%b rd=%h wr=%h exp all 0",
               dataOUT_, rd_slot, prot_err, rd_count, wr_count);
    end
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    wait_ready();
  endtask

  task automatic test_write_read();
    tick(1'b0, 1'b1, 12'h010, 16'h1234);
    n_checks++;
    if (wr_count !== 16'd1 || dataOUT_ !== 16'h1234) begin
      n_fail++;
      $display("FAIL wr_first got dout=%h wr=%h exp dout=1234 wr=0001", dataOUT_, wr_count);
    end
    tick(1'b0, 1'b0, 12'h010, 16'h0);
    n_checks++;
    if (dataOUT_ !== 16'h1234 || rd_count !== 16'd1 || wr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL wr_rd got dout=%h rd=%h wr=%h exp 1234/0001/0001", dataOUT_, rd_count, wr_count);
    end
  endtask

  task automatic test_protect();
    logic [11:0] pa [3];
    pa[0] = 12'hEFF; pa[1] = 12'hF00; pa[2] = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, pa[i], 16'hBEEF);
      n_checks++;
      if (prot_err !== m_prot || wr_count !== 16'(m_wr)) begin
        n_fail++;
        $display("FAIL prot_wr a=%h got perr=%b wr=%h exp perr=%b wr=%h",
                 pa[i], prot_err, wr_count, m_prot, 16'(m_wr));
      end
      tick(1'b0, 1'b0, pa[i], 16'h0);
      n_checks++;
      if (prot_err !== 1'b0) begin
        n_fail++;
        $display("FAIL prot_pulse a=%h got=%b exp=0", pa[i], prot_err);
      end
      n_checks++;
      if (m_dval ? (dataOUT_ !== m_dout) : (dataOUT_ === 16'hBEEF)) begin
        n_fail++;
        $display("FAIL prot_rd a=%h got=%h exp=%h known=%b", pa[i], dataOUT_, m_dout, m_dval);
      end
    end
  endtask

  task automatic test_slot();
    tick(1'b0, 1'b1, 12'h001, 16'hAAAA);
    tick(1'b0, 1'b1, 12'h002, 16'h5555);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, (i % 2 == 0) ? 12'h001 : 12'h002, 16'h0);
      n_checks++;
      if (dataOUT_ !== m_dout || rd_slot !== m_slot_out) begin
        n_fail++;
        $display("FAIL slot_alt i=%0d got dout=%h slot=%b exp dout=%h slot=%b",
                 i, dataOUT_, rd_slot, m_dout, m_slot_out);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    bit w;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        7:       a = 12'hEFF;
        8:       a = PROT + 12'($urandom_range(0, 3));
        9:       a = 12'hFFF;
        default: a = 12'($urandom_range(0, 15));
      endcase
      w = 1'($urandom_range(0, 1));
      tick(1'b0, w, a, 16'($urandom));
      n_checks++;
      if ((m_dval && dataOUT_ !== m_dout) || rd_slot !== m_slot_out || prot_err !== m_prot ||
          rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr)) begin
        n_fail++;
        $display("FAIL random i=%0d a=%h we=%b got %h/%b/%b/%h/%h exp %h/%b/%b/%h/%h", i, a, w,
                 dataOUT_, rd_slot, prot_err, rd_count, wr_count,
                 m_dout, m_slot_out, m_prot, 16'(m_rd), 16'(m_wr));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a;
    logic [15:0] d;
    for (int i = 0; i < 12; i++) begin
      a = 12'($urandom_range(0, 12'hEFF));
      d = 16'($urandom);
      tick(1'b0, 1'b1, a, d);
      tick(1'b0, 1'b0, a, 16'h0);
      n_checks++;
      if (dataOUT_ !== d || rd_count !== 16'(m_rd)) begin
        n_fail++;
        $display("FAIL b2b a=%h got=%h exp=%h rd=%h exp_rd=%h", a, dataOUT_, d, rd_count, 16'(m_rd));
      end
    end
  endtask

  task automatic test_midreset();
    tick(1'b0, 1'b1, 12'h020, 16'hC0DE);
    tick(1'b0, 1'b0, 12'h003, 16'h0);
    tick(1'b1, 1'b1, 12'h020, 16'hDEAD);
    n_checks++;
    if ({dataOUT_, rd_slot, prot_err, rd_count, wr_count} !== 50'd0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got dout=%h slot=%b perr=%b rd=%h wr=%h rdy=%b exp all 0",
               dataOUT_, rd_slot, prot_err, rd_count, wr_count, ready);
    end
    wait_ready();
    tick(1'b0, 1'b0, 12'h020, 16'h0);
    n_checks++;
    if (dataOUT_ !== m_dout || rd_slot !== 1'b0 || rd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL retain got dout=%h slot=%b rd=%h exp dout=%h slot=0 rd=0001",
               dataOUT_, rd_slot, rd_count, m_dout);
    end
  endtask

`ifdef SHARED_MEM_CLEAR_EN
  task automatic test_clear();
    int low;
    tick(1'b1, 1'b0, 12'h000, 16'h0);
    for (int i = 0; i < 2000; i++) tick(1'b0, (i == 3), 12'h005, 16'h7777);
    tick(1'b1, 1'b0, 12'h000, 16'h0);
    low = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1'b0, (i == 10), 12'h005, 16'h7777);
      low++;
      if (ready === 1'b1) break;
    end
    n_checks++;
    if (low != 4096 || m_ready != 1'b1) begin
      n_fail++;
      $display("FAIL clear_len got=%0d exp=4096", low);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b0, 12'(i), 16'h0);
      n_checks++;
      if (dataOUT_ !== 16'h0000) begin
        n_fail++;
        $display("FAIL clear_data a=%h got=%h exp=0000", 12'(i), dataOUT_);
      end
    end
  endtask
`endif

  task automatic test_saturate();
    while (m_rd < 65534) tick(1'b0, 1'b0, 12'h010, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 12'h010, 16'h0);
      n_checks++;
      if (rd_count !== 16'hFFFF || rd_count !== 16'(m_rd)) begin
        n_fail++;
        $display("FAIL rd_sat i=%0d got=%h exp=ffff", i, rd_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_protect();
    test_slot();
    test_random();
    test_back_to_back();
    test_midreset();
`ifdef SHARED_MEM_CLEAR_EN
    test_clear();
`endif
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
